// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM encoding, segment patterns, digit count.
// Latency: n/a (constants and a pure decode function).
// Backpressure: n/a.
package ssd_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  // Active-low segments {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/ssd_scan_controller_if.sv
// Bus between the processor's ssd output and the display pins.
// Latency: n/a (wires only).
// Backpressure: load is honoured only while busy==0; otherwise dropped, never queued.
//   value/load : processor -> controller ; busy : controller -> processor
//   anode/cathode : controller -> board pins (active low)
interface ssd_scan_controller_if #(parameter int VAL_W = 13);
  logic [VAL_W-1:0] value;
  logic             load;
  logic             busy;
  logic [3:0]       anode;
  logic [6:0]       cathode;

  modport master (output value, output load, input busy, input anode, input cathode);
  modport slave  (input value, input load, output busy, output anode, output cathode);
endinterface

// File: rtl/ssd_scan_controller_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter (IDLE -> SHIFT -> DONE).
// Latency: busy spans VAL_W+2 cycles from the start edge; done is high in the final busy cycle.
// Backpressure: start is ignored unless in IDLE.
//   clk, rst(sync, high) ; start, bin : request ; busy, done, bcd[15:0] : status/result
module bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int VAL_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VAL_W-1:0] bin,
  output logic             busy,
  output logic [15:0]      bcd,
  output logic             done
);

  localparam int CNT_W = $clog2(VAL_W + 1);

  conv_state_e      state_q, state_d;
  logic [VAL_W-1:0] bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      bcd_adj;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  // SHIFT performs VAL_W shifts, then lingers one cycle at cnt==VAL_W so busy
  // spans VAL_W+2 cycles and the result lands VAL_W+2 edges after the start edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == CNT_W'(VAL_W)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end

    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_d = bin;
          bcd_d = '0;
          cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != CNT_W'(VAL_W)) begin
          // Add-3 and shift in one cycle; BCD bits beyond 4 digits fall off the top.
          bcd_d = {bcd_adj[14:0], bin_q[VAL_W-1]};
          bin_d = {bin_q[VAL_W-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
    bcd  = bcd_q;
  end

endmodule

// File: rtl/ssd_scan_controller.sv
// Four-digit seven-segment driver: converts the ssd value to BCD and time-multiplexes the digits.
// Latency: display updates VAL_W+2 edges after an accepted load; pins lag index/digit changes by 1 cycle.
// Backpressure: load while busy is dropped; the scan never stalls.
//   clk, rst(sync, high) ; bus.slave : value, load -> ; busy, anode[3:0], cathode[6:0] <-
module ssd_scan_controller
  import ssd_pkg::*;
#(
  parameter int VAL_W       = 13,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  ssd_scan_controller_if.slave bus
);

  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [REF_W-1:0] ref_q, ref_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      disp_q, disp_d;
  logic [3:0]       anode_q, anode_d;
  logic [6:0]       cathode_q, cathode_d;

  logic [15:0]      conv_bcd;
  logic             conv_busy;
  logic             conv_done;
  logic [3:0]       cur_digit;
  logic             lead_zero;

  bin2bcd_seq #(.VAL_W(VAL_W)) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (bus.load),
    .bin   (bus.value),
    .busy  (conv_busy),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q     <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      anode_q   <= 4'b1111;
      cathode_q <= SEG_BLANK;
    end else begin
      ref_q     <= ref_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  always_comb begin
    if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      ref_d = ref_q + 1'b1;
      idx_d = idx_q;
    end
    disp_d = conv_done ? conv_bcd : disp_q;
  end

  // Decode straight from disp_q so a new result shows on the very next cycle,
  // even mid-slot. lead_zero: this digit and every higher digit are zero.
  always_comb begin
    cur_digit = disp_q[{idx_q, 2'b00} +: 4];
    lead_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx_q) && disp_q[i*4 +: 4] != 4'd0) lead_zero = 1'b0;
    end
    anode_d   = ~(4'b0001 << idx_q);
    cathode_d = seg_decode(cur_digit);
    if (BLANK_LZ != 0 && idx_q != 2'd0 && lead_zero) begin
      anode_d   = 4'b1111;
      cathode_d = SEG_BLANK;
    end
  end

  assign bus.busy    = conv_busy;
  assign bus.anode   = anode_q;
  assign bus.cathode = cathode_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Bench for ssd_scan_controller: directed scenarios then random loads/resets,
// two instances (leading-zero blanking on and off) checked every cycle against
// a decimal-arithmetic model of the display.
module tb_ssd_scan_controller;

  localparam int VAL_W   = 13;
  localparam int REF_DIV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ssd_scan_controller_if #(.VAL_W(VAL_W)) bus_lz ();
  ssd_scan_controller_if #(.VAL_W(VAL_W)) bus_all ();

  ssd_scan_controller #(.VAL_W(VAL_W), .REFRESH_DIV(REF_DIV), .BLANK_LZ(1)) u_dut_lz (
    .clk (clk),
    .rst (rst),
    .bus (bus_lz)
  );

  ssd_scan_controller #(.VAL_W(VAL_W), .REFRESH_DIV(REF_DIV), .BLANK_LZ(0)) u_dut_all (
    .clk (clk),
    .rst (rst),
    .bus (bus_all)
  );

  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int pow10 [4] = '{1, 10, 100, 1000};

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: cycles since reset, shown decimal value, remaining busy cycles, pending value.
  int m_t    = 0;
  int m_disp = 0;
  int m_left = 0;
  int m_pend = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  // Pin pattern for the slot active at cycle t when the display holds disp.
  task automatic exp_pins(input bit blank_lz, input int t, input int disp,
                          output logic [3:0] an, output logic [6:0] ca);
    int idx;
    idx = (t / REF_DIV) % 4;
    if (blank_lz && idx > 0 && disp < pow10[idx]) begin
      an = 4'b1111;
      ca = 7'b1111111;
    end else begin
      an = ~(4'b0001 << idx);
      ca = seg_tbl[(disp / pow10[idx]) % 10];
    end
  endtask

  task automatic step(input logic r, input logic ld, input int v);
    logic [3:0] ea_lz, ea_all;
    logic [6:0] ec_lz, ec_all;
    logic [VAL_W-1:0] vv;
    vv = v[VAL_W-1:0];
    rst           = r;
    bus_lz.load   = ld;
    bus_all.load  = ld;
    bus_lz.value  = vv;
    bus_all.value = vv;
    @(posedge clk);
    if (r) begin
      ea_lz = 4'b1111; ec_lz = 7'b1111111;
      ea_all = 4'b1111; ec_all = 7'b1111111;
      m_t = 0; m_disp = 0; m_left = 0;
    end else begin
      exp_pins(1'b1, m_t, m_disp, ea_lz, ec_lz);
      exp_pins(1'b0, m_t, m_disp, ea_all, ec_all);
      m_t++;
      if (m_left == 0) begin
        if (ld) begin
          m_left = VAL_W + 2;
          m_pend = int'(vv);
        end
      end else begin
        m_left--;
        if (m_left == 0) m_disp = m_pend % 10000;
      end
    end
    #1;
    chk("anode_lz",    {28'd0, bus_lz.anode},    {28'd0, ea_lz});
    chk("cathode_lz",  {25'd0, bus_lz.cathode},  {25'd0, ec_lz});
    chk("busy_lz",     {31'd0, bus_lz.busy},     {31'd0, (m_left != 0)});
    chk("anode_all",   {28'd0, bus_all.anode},   {28'd0, ea_all});
    chk("cathode_all", {25'd0, bus_all.cathode}, {25'd0, ec_all});
    chk("busy_all",    {31'd0, bus_all.busy},    {31'd0, (m_left != 0)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
  endtask

  task automatic show(input int v);
    step(1'b0, 1'b1, v);
    idle(40);
  endtask

  int rv;
  int mode;

  initial begin
    rst = 1'b1;
    bus_lz.load = 1'b0;  bus_all.load = 1'b0;
    bus_lz.value = '0;   bus_all.value = '0;

    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    idle(20);

    show(1234);
    show(8191);
    show(0);
    show(7);

    // Second load lands while busy and must be dropped.
    step(1'b0, 1'b1, 1234);
    idle(3);
    step(1'b0, 1'b1, 999);
    idle(40);

    // Reset mid-conversion, then reconvert.
    step(1'b0, 1'b1, 4321);
    idle(6);
    step(1'b1, 1'b0, 0);
    idle(10);
    show(4321);

    // Reset and load together: reset wins.
    step(1'b1, 1'b1, 555);
    idle(20);

    show(10);
    show(100);
    show(1000);

    for (int i = 0; i < 3000; i++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0:       rv = $urandom_range(0, 9);
        1:       rv = $urandom_range(0, 99);
        2:       rv = $urandom_range(0, 999);
        default: rv = $urandom_range(0, 8191);
      endcase
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0), rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
